// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, default NOP encoding,
// sequential PC increment and the fetch FSM state type.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR           = 32'd4;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Control priority: reset > flush > hold > load.
// A flush (or reset) leaves a bubble: pc=0, instr=NOP_INSTR, valid=0.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            valid
);

    // Register update: bubble on reset/flush, keep on hold, capture on load.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (hold) begin
            pc    <= pc;
            instr <= instr;
            valid <= valid;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry hold buffer and the
// IF/ID register. Optional performance counters are built when the macro
// IF_STAGE_PERF_EN is defined (outputs stall_cycles and flush_count).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH_REQ  | imem_req=1; waiting for imem_ready to accept an instruction
// FETCH_HOLD | fetched word parked in hold buffer while freeze is high
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            freeze,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_wait
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [15:0]     flush_count
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;

    logic            ifid_load;
    logic            ifid_hold;
    logic            ifid_flush;
    logic [XLEN-1:0] ifid_load_pc;
    logic [XLEN-1:0] ifid_load_instr;

    // Wraps modulo 2^32 by width.
    assign pc_seq     = pc + PC_INCR;
    assign imem_addr  = pc;
    // Gated by rst_n so a fetch is abandoned as soon as reset is asserted.
    assign imem_req   = rst_n && (state == FETCH_REQ);
    assign fetch_wait = imem_req && !imem_ready;

    // Fetch FSM, PC and hold buffer; branch overrides freeze and any data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH_REQ;
            pc         <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else if (branch_taken) begin
            state      <= FETCH_REQ;
            pc         <= branch_addr;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (imem_ready) begin
                        if (freeze) begin
                            hold_pc    <= pc_seq;
                            hold_instr <= imem_rdata;
                            state      <= FETCH_HOLD;
                        end else begin
                            pc <= pc_seq;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (!freeze) begin
                        pc    <= pc_seq;
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

    // IF/ID control: flush on branch or on an unfrozen empty fetch cycle.
    always_comb begin
        ifid_flush      = 1'b0;
        ifid_load       = 1'b0;
        ifid_load_pc    = pc_seq;
        ifid_load_instr = imem_rdata;
        if (branch_taken) begin
            ifid_flush = 1'b1;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (!freeze) begin
                        if (imem_ready) begin
                            ifid_load = 1'b1;
                        end else begin
                            ifid_flush = 1'b1;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (!freeze) begin
                        ifid_load       = 1'b1;
                        ifid_load_pc    = hold_pc;
                        ifid_load_instr = hold_instr;
                    end
                end
                default: ifid_flush = 1'b1;
            endcase
        end
        ifid_hold = !ifid_flush && !ifid_load;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ifid_load),
        .hold       (ifid_hold),
        .flush      (ifid_flush),
        .load_pc    (ifid_load_pc),
        .load_instr (ifid_load_instr),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .valid      (if_id_valid)
    );

`ifdef IF_STAGE_PERF_EN
    // Saturating stall and flush counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((freeze || fetch_wait) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word driven on if_id_instr when the register is flushed or reset.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 freeze  in  1  stall request from the hazard detection unit; holds PC and IF/ID.
REQ-006 branch_taken  in  1  redirect request from EXE.
REQ-007 branch_addr  in  32  redirect target.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 imem_addr  out  32  fetch address, equal to PC.
REQ-010 imem_ready  in  1  fetch completes in the cycle imem_req&imem_ready.
REQ-011 imem_rdata  in  32  instruction; valid only when imem_ready=1.
REQ-012 if_id_pc  out  32  PC+4 of the held instruction.
REQ-013 if_id_instr  out  32  held instruction.
REQ-014 if_id_valid  out  1  IF/ID holds a real instruction.
REQ-015 fetch_wait  out  1  high while in REQ with imem_ready=0.

Function
REQ-016 FSM states: REQ and HOLD; reset state REQ.
REQ-017 REQ: imem_req=1; HOLD: imem_req=0; imem_addr=PC always.
REQ-018 Priority per cycle: rst_n=0 > branch_taken > freeze > normal.
REQ-019 branch_taken=1 in any state: PC<=branch_addr, IF/ID<={0,NOP_INSTR,valid=0}, hold buffer discarded, next state REQ, any concurrent imem_rdata dropped.
REQ-020 REQ with imem_ready=1 and freeze=0: IF/ID<={PC+4, imem_rdata, 1}, PC<=PC+4, stay REQ.
REQ-021 REQ with imem_ready=1 and freeze=1: imem_rdata captured into hold buffer with PC+4, IF/ID and PC unchanged, next state HOLD.
REQ-022 REQ with imem_ready=0: freeze=1 holds IF/ID; freeze=0 writes bubble (valid=0, NOP_INSTR); PC unchanged.
REQ-023 HOLD with freeze=1: all state held; HOLD with freeze=0: IF/ID<=hold buffer (valid=1), PC<=PC+4, next state REQ.
REQ-024 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 Latency: instruction appears on IF/ID outputs the cycle after imem_ready, absent freeze and branch.
REQ-026 No instruction SHALL be lost or duplicated across any freeze/ready/branch interleaving.

Reset
REQ-027 On rising clk with rst_n=0: PC=RESET_PC, state=REQ, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, hold buffer cleared.
REQ-028 While rst_n=0, imem_req SHALL be 0 and fetch_wait 0; reset mid-fetch abandons the request.

Configuration
REQ-029 Macro IF_STAGE_PERF_EN defined: extra outputs stall_cycles (32, counts cycles with freeze=1 or fetch_wait=1) and flush_count (16, counts branch_taken cycles), both saturating, cleared by reset.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package cpu_pkg SHALL hold the fetch-state typedef, XLEN=32, NOP_INSTR default, and PC increment constant 4.
REQ-032 IF/ID register SHALL be a sub-module if_id_reg with load, hold, and flush controls; FSM and PC stay in if_stage.

Verification
REQ-033 Reset, then imem_ready=1 constant: if_id_pc sequence 4,8,12; imem_addr 0,4,8.
REQ-034 freeze=1 three cycles while imem_ready=1 at PC=8: IF/ID holds instr@4; on release instr@8 appears once, PC->12.
REQ-035 branch_taken=1, branch_addr=32'h100 during HOLD: next imem_addr=32'h100, if_id_valid=0, held instr dropped.
REQ-036 imem_ready=0 two cycles, freeze=0: two bubbles (valid=0), fetch_wait=1, PC unchanged.
REQ-037 rst_n=0 during REQ with PC=32'h40: next cycle PC=RESET_PC, valid=0, imem_req=0 while reset held.
REQ-038 With IF_STAGE_PERF_EN: 5 freeze cycles plus 2 branches -> stall_cycles=5, flush_count=2.
